// File: rtl/fpu_div_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_div_ctrl
//   Control/datapath wrapper around an external sequential mantissa divider
//   for IEEE-754 single-precision division. Unpacks the operands, resolves
//   special cases (NaN, inf, zero) without touching the divider, otherwise
//   hands the 24-bit mantissas to the divider over a level start/done
//   handshake, normalises the quotient (truncation) and packs the result.
//   Denormal operands are flushed to zero.
//
// Parameters
//   DIV_TIMEOUT   divider watchdog limit in clk cycles (1..1023)
//
// Ports
//   clk           clock, rising edge
//   arst          asynchronous reset, active low
//   start         level request from the FPU sequencer
//   a, b          dividend / divisor (IEEE-754 single)
//   result        packed quotient
//   done          result valid, held until start drops
//   div_by_zero, invalid, overflow, underflow, timeout   status flags
//   div_dividend  24-bit mantissa (hidden bit included) to the divider
//   div_divisor   24-bit mantissa (hidden bit included) to the divider
//   div_start     level request to the divider
//   div_quotient  divider result: floor(dividend*2^23/divisor) mod 2^24
//   div_done      divider result valid
//
// Build option
//   FPU_DIV_TIMEOUT_EN  enables the divider watchdog. Without it the waits on
//                       the divider are unbounded and timeout is tied low.
// ---------------------------------------------------------------------------
module fpu_div_ctrl #(
    parameter int unsigned DIV_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        done,
    output logic        div_by_zero,
    output logic        invalid,
    output logic        overflow,
    output logic        underflow,
    output logic        timeout,
    output logic [23:0] div_dividend,
    output logic [23:0] div_divisor,
    output logic        div_start,
    input  logic [23:0] div_quotient,
    input  logic        div_done
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    if (DIV_TIMEOUT < 1 || DIV_TIMEOUT > 1023) begin : g_bad_timeout
        $error("fpu_div_ctrl: DIV_TIMEOUT must be in 1..1023");
    end

    typedef enum logic [3:0] {
        IDLE,
        UNPACK,
        CLASSIFY,
        DIV_REQ,
        DIV_WAIT,
        DIV_RELEASE,
        NORM,
        PACK,
        DONE
    } state_t;

    state_t r_state, w_next;

    // latched operands
    logic [31:0] r_a, r_b;

    // unpacked fields
    logic        r_sign;
    logic [7:0]  r_ea, r_eb;
    logic [23:0] r_ma, r_mb;
    logic        r_a_zero, r_a_inf, r_a_nan;
    logic        r_b_zero, r_b_inf, r_b_nan;

    // working exponent and quotient
    logic signed [9:0] r_exp;
    logic [23:0]       r_quot;

    // special-case result resolved ahead of PACK
    logic        r_spec;
    logic [31:0] r_spec_res;
    logic        r_spec_inv, r_spec_dbz;

    // output registers
    logic [31:0] r_result;
    logic        r_done;
    logic        r_dbz, r_inv, r_ovf, r_unf;
    logic [23:0] r_div_dividend, r_div_divisor;
    logic        r_div_start;

    logic        w_to_hit;

    // ---------------------------------------------------------------------
    // Special-case classification (from registered operand flags).
    // The chain below is a strict priority order; each term may assume the
    // earlier ones are false.
    // ---------------------------------------------------------------------
    logic        w_any_nan, w_inv, w_dbz, w_inf_res, w_zero_res, w_special;
    logic [31:0] w_spec_res;

    always_comb begin
        w_any_nan  = r_a_nan | r_b_nan;
        w_inv      = (r_a_zero & r_b_zero) | (r_a_inf & r_b_inf);
        // inf/0 is not a divide-by-zero: it falls through to the inf result
        w_dbz      = r_b_zero & ~r_a_zero & ~r_a_inf;
        w_inf_res  = r_a_inf;
        w_zero_res = r_a_zero | r_b_inf;
        w_special  = w_any_nan | w_inv | w_dbz | w_inf_res | w_zero_res;

        w_spec_res = {r_sign, 31'h0};
        if (w_any_nan || w_inv)
            w_spec_res = QNAN;
        else if (w_dbz || w_inf_res)
            w_spec_res = {r_sign, 8'hFF, 23'h0};
    end

    // ---------------------------------------------------------------------
    // Divider watchdog
    // ---------------------------------------------------------------------
`ifdef FPU_DIV_TIMEOUT_EN
    logic [9:0] r_to_cnt;
    logic       r_spec_to;
    logic       r_timeout;

    // r_to_cnt holds the number of wait cycles already completed, so the
    // limit is reached during the DIV_TIMEOUT-th cycle in the wait states.
    assign w_to_hit = ((r_state == DIV_WAIT) || (r_state == DIV_RELEASE)) &&
                      (r_to_cnt == 10'(DIV_TIMEOUT - 1));

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_to_cnt <= '0;
        end else if (w_next == DIV_REQ) begin
            r_to_cnt <= '0;
        end else if ((r_state == DIV_WAIT) || (r_state == DIV_RELEASE)) begin
            r_to_cnt <= r_to_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_spec_to <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_spec_to <= 1'b0;
                r_timeout <= 1'b0;
            end
            if (w_to_hit)
                r_spec_to <= 1'b1;
            if (r_state == PACK)
                r_timeout <= r_spec_to;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_to_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst) begin
        if (!arst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:        if (start) w_next = UNPACK;
            UNPACK:      w_next = CLASSIFY;
            CLASSIFY:    w_next = w_special ? PACK : DIV_REQ;
            DIV_REQ:     w_next = DIV_WAIT;
            DIV_WAIT: begin
                if (w_to_hit)      w_next = PACK;
                else if (div_done) w_next = DIV_RELEASE;
            end
            DIV_RELEASE: begin
                if (w_to_hit)       w_next = PACK;
                else if (!div_done) w_next = NORM;
            end
            NORM:        w_next = PACK;
            PACK:        w_next = DONE;
            // done is only raised one cycle into DONE, so r_done gates the
            // exit: an early-dropped start still yields a single done cycle.
            DONE:        if (r_done && !start) w_next = IDLE;
            default:     w_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_a            <= '0;
            r_b            <= '0;
            r_sign         <= 1'b0;
            r_ea           <= '0;
            r_eb           <= '0;
            r_ma           <= '0;
            r_mb           <= '0;
            r_a_zero       <= 1'b0;
            r_a_inf        <= 1'b0;
            r_a_nan        <= 1'b0;
            r_b_zero       <= 1'b0;
            r_b_inf        <= 1'b0;
            r_b_nan        <= 1'b0;
            r_exp          <= '0;
            r_quot         <= '0;
            r_spec         <= 1'b0;
            r_spec_res     <= '0;
            r_spec_inv     <= 1'b0;
            r_spec_dbz     <= 1'b0;
            r_result       <= '0;
            r_done         <= 1'b0;
            r_dbz          <= 1'b0;
            r_inv          <= 1'b0;
            r_ovf          <= 1'b0;
            r_unf          <= 1'b0;
            r_div_dividend <= '0;
            r_div_divisor  <= '0;
            r_div_start    <= 1'b0;
        end else begin
            // registered request: high throughout DIV_REQ and DIV_WAIT only
            r_div_start <= (w_next == DIV_REQ) || (w_next == DIV_WAIT);
            r_done      <= 1'b0;

            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_spec <= 1'b0;
                        r_dbz  <= 1'b0;
                        r_inv  <= 1'b0;
                        r_ovf  <= 1'b0;
                        r_unf  <= 1'b0;
                    end
                end
                UNPACK: begin
                    r_sign   <= r_a[31] ^ r_b[31];
                    r_ea     <= r_a[30:23];
                    r_eb     <= r_b[30:23];
                    r_ma     <= (r_a[30:23] == 8'h00) ? 24'h0 : {1'b1, r_a[22:0]};
                    r_mb     <= (r_b[30:23] == 8'h00) ? 24'h0 : {1'b1, r_b[22:0]};
                    r_a_zero <= (r_a[30:23] == 8'h00);
                    r_b_zero <= (r_b[30:23] == 8'h00);
                    r_a_inf  <= (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'h0);
                    r_b_inf  <= (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'h0);
                    r_a_nan  <= (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'h0);
                    r_b_nan  <= (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'h0);
                end
                CLASSIFY: begin
                    if (w_special) begin
                        r_spec     <= 1'b1;
                        r_spec_res <= w_spec_res;
                        r_spec_inv <= ~w_any_nan & w_inv;
                        r_spec_dbz <= ~w_any_nan & ~w_inv & w_dbz;
                    end else begin
                        r_exp          <= $signed({2'b00, r_ea}) - $signed({2'b00, r_eb})
                                          + 10'sd127;
                        r_div_dividend <= r_ma;
                        r_div_divisor  <= r_mb;
                    end
                end
                DIV_WAIT, DIV_RELEASE: begin
                    if (w_to_hit) begin
                        r_spec     <= 1'b1;
                        r_spec_res <= QNAN;
                        r_spec_inv <= 1'b0;
                        r_spec_dbz <= 1'b0;
                    end else if (r_state == DIV_WAIT && div_done) begin
                        r_quot <= div_quotient;
                    end
                end
                NORM: begin
                    // operands in [1,2) give a quotient in (0.5,2): at most
                    // one left shift is needed
                    if (!r_quot[23]) begin
                        r_quot <= {r_quot[22:0], 1'b0};
                        r_exp  <= r_exp - 10'sd1;
                    end
                end
                PACK: begin
                    if (r_spec) begin
                        r_result <= r_spec_res;
                        r_inv    <= r_spec_inv;
                        r_dbz    <= r_spec_dbz;
                    end else if (r_exp >= 10'sd255) begin
                        r_result <= {r_sign, 8'hFF, 23'h0};
                        r_ovf    <= 1'b1;
                    end else if (r_exp <= 10'sd0) begin
                        r_result <= {r_sign, 31'h0};
                        r_unf    <= 1'b1;
                    end else begin
                        r_result <= {r_sign, r_exp[7:0], r_quot[22:0]};
                    end
                end
                DONE: begin
                    r_done <= ~(r_done & ~start);
                end
                default: ;
            endcase
        end
    end

    assign result       = r_result;
    assign done         = r_done;
    assign div_by_zero  = r_dbz;
    assign invalid      = r_inv;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;
    assign div_dividend = r_div_dividend;
    assign div_divisor  = r_div_divisor;
    assign div_start    = r_div_start;

endmodule

// File: tb/tb_fpu_div_ctrl.sv
// Bench for fpu_div_ctrl: directed and randomized divisions against a
// behavioural IEEE-754 division model. Expected responses are queued at
// issue time and compared by an independent monitor on each done pulse.
module tb_fpu_div_ctrl;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam int DIV_LAT = 50;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] result;
  logic        done, div_by_zero, invalid, overflow, underflow, timeout;
  logic [23:0] div_dividend, div_divisor, div_quotient;
  logic        div_start, div_done;

  always #5 clk = ~clk;

  fpu_div_ctrl #(.DIV_TIMEOUT(255)) u_dut (
    .clk(clk), .arst(arst), .start(start), .a(a), .b(b),
    .result(result), .done(done), .div_by_zero(div_by_zero),
    .invalid(invalid), .overflow(overflow), .underflow(underflow),
    .timeout(timeout), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_start(div_start), .div_quotient(div_quotient), .div_done(div_done)
  );

  // divider model: result after DIV_LAT cycles of div_start, held until released
  int dv_cnt;
  always @(posedge clk or negedge arst) begin
    if (!arst) begin
      dv_cnt <= 0; div_done <= 1'b0; div_quotient <= '0;
    end else if (div_start && !div_done) begin
      if (dv_cnt == DIV_LAT - 1) begin
        div_done     <= 1'b1;
        div_quotient <= (div_divisor == 0) ? 24'hFFFFFF :
                        24'((longint'(div_dividend) * 64'd8388608) / longint'(div_divisor));
        dv_cnt       <= 0;
      end else
        dv_cnt <= dv_cnt + 1;
    end else if (!div_start) begin
      div_done <= 1'b0; dv_cnt <= 0;
    end
  end

  typedef struct packed {
    logic [31:0] res;
    logic dbz, inv, ovf, unf, to;
  } resp_t;

  resp_t exp_q[$];
  int n_checks = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) ||
           (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
  endfunction

  // reference: IEEE single division, denormals flushed, truncation
  function automatic resp_t model(input logic [31:0] x, input logic [31:0] y);
    resp_t r;
    int ex, ey, e;
    logic s;
    longint mx, my, q;
    bit nx, ny, ix, iy, zx, zy;
    r  = '0;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    zx = (ex == 0);
    zy = (ey == 0);
    if (nx || ny) r.res = QNAN;
    else if ((zx && zy) || (ix && iy)) begin r.res = QNAN; r.inv = 1'b1; end
    else if (zy && !ix) begin r.res = {s, 8'hFF, 23'h0}; r.dbz = 1'b1; end
    else if (ix) r.res = {s, 8'hFF, 23'h0};
    else if (zx || iy) r.res = {s, 31'h0};
    else begin
      mx = longint'({1'b1, x[22:0]});
      my = longint'({1'b1, y[22:0]});
      q  = (mx * 8388608) / my;
      e  = ex - ey + 127;
      if (q < 8388608) begin q = q * 2; e = e - 1; end
      if (e >= 255) begin r.res = {s, 8'hFF, 23'h0}; r.ovf = 1'b1; end
      else if (e <= 0) begin r.res = {s, 31'h0}; r.unf = 1'b1; end
      else r.res = {s, e[7:0], q[22:0]};
    end
    return r;
  endfunction

  // monitor: one scoreboard pop per rising edge of done
  logic done_q = 1'b0;
  resp_t mon_e;
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL unexpected_done: result %h with no operation pending", result);
      end else begin
        mon_e = exp_q.pop_front();
        chk("response", 64'({result, div_by_zero, invalid, overflow, underflow, timeout}),
            64'(mon_e));
      end
    end
    done_q <= done;
  end

  // one operation; hold=1 keeps start high past done
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input bit hold);
    resp_t e;
    bit spec, saw_ds, got;
    int cyc;
    logic [23:0] cap_dd, cap_dv;
    e = model(x, y);
    spec = is_special(x, y);
    saw_ds = 0; got = 0; cyc = 0; cap_dd = '0; cap_dv = '0;
    exp_q.push_back(e);
    @(negedge clk); a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    a = $urandom; b = $urandom;
    while (!got && cyc < 400) begin
      @(negedge clk);
      if (div_start && !saw_ds) begin
        saw_ds = 1; cap_dd = div_dividend; cap_dv = div_divisor;
      end
      if (done) got = 1;
      else begin @(posedge clk); cyc++; end
    end
    if (!got) begin
      n_checks++; n_err++;
      $display("FAIL done_timeout: no done for %h/%h after %0d cycles", x, y, cyc);
      return;
    end
    chk("div_start_used", 64'(saw_ds), 64'(!spec));
    if (spec) chk("special_latency", 64'(cyc), 64'd4);
    else chk("div_operands", {16'h0, cap_dd, cap_dv}, {16'h0, 1'b1, x[22:0], 1'b1, y[22:0]});
    if (!hold) begin
      @(negedge clk);
      chk("done_single_pulse", 64'(done), 64'd0);
    end else begin
      repeat (2) begin
        @(negedge clk);
        chk("done_hold", 64'({done, result}), 64'({1'b1, e.res}));
      end
      start = 1'b0;
      @(negedge clk);
      chk("done_release", 64'(done), 64'd0);
    end
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0] ex;
    logic [22:0] fr;
    int sel;
    sel = $urandom_range(0, 9);
    fr  = 23'($urandom);
    case (sel)
      0: ex = 8'h00;
      1: begin ex = 8'hFF; fr = '0; end
      2: begin ex = 8'hFF; fr = fr | 23'h1; end
      3: ex = 8'($urandom_range(1, 254));
      default: ex = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), ex, fr};
  endfunction

`ifdef FPU_DIV_TIMEOUT_EN
  logic        t_start = 1'b0;
  logic [31:0] t_a = '0, t_b = '0, t_result;
  logic        t_done, t_dbz, t_inv, t_ovf, t_unf, t_to, t_div_start;
  logic [23:0] t_dd, t_dv;
  fpu_div_ctrl #(.DIV_TIMEOUT(16)) u_dut_to (
    .clk(clk), .arst(arst), .start(t_start), .a(t_a), .b(t_b),
    .result(t_result), .done(t_done), .div_by_zero(t_dbz),
    .invalid(t_inv), .overflow(t_ovf), .underflow(t_unf),
    .timeout(t_to), .div_dividend(t_dd), .div_divisor(t_dv),
    .div_start(t_div_start), .div_quotient(24'h0), .div_done(1'b0)
  );
`endif

  initial begin
    int w;
    logic [31:0] ra, rb;
    #12;
    chk("reset_outputs",
        64'({result, done, div_by_zero, invalid, overflow, underflow, timeout,
             div_start, div_dividend[15:0]}), 64'd0);
    chk("reset_div_operands", 64'({div_dividend, div_divisor}), 64'd0);
    @(negedge clk); arst = 1'b1;
    repeat (2) @(negedge clk);

    run_op(32'h4040_0000, 32'h3F80_0000, 1);  // 3/1
    run_op(32'h3F80_0000, 32'h4040_0000, 0);  // 1/3, normalises
    run_op(32'h3F80_0000, 32'h0000_0000, 1);  // 1/0
    run_op(32'h0000_0000, 32'h0000_0000, 0);  // 0/0
    run_op(32'h7F00_0000, 32'h0080_0000, 1);  // overflow
    run_op(32'h0080_0000, 32'h7F00_0000, 0);  // underflow
    run_op(32'h7FC0_0001, 32'h3F80_0000, 0);  // NaN operand
    run_op(32'hFF80_0000, 32'h7F80_0000, 1);  // inf/inf
    run_op(32'h7F80_0000, 32'h8000_0000, 0);  // inf/0 -> -inf, no flag
    run_op(32'h8000_0000, 32'h4000_0000, 0);  // -0/2
    run_op(32'h4120_0000, 32'hFF80_0000, 0);  // finite/inf

    // reset while the divider is busy
    @(negedge clk); a = 32'h4040_0000; b = 32'h3F80_0000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    w = 0;
    while (!div_start && w < 20) begin @(negedge clk); w++; end
    chk("abort_div_busy", 64'(div_start), 64'd1);
    repeat (10) @(negedge clk);
    #2 arst = 1'b0;
    #1 chk("abort_outputs",
           64'({result, done, div_start, div_by_zero, invalid, overflow, underflow, timeout}),
           64'd0);
    chk("abort_div_operands", 64'({div_dividend, div_divisor}), 64'd0);
    repeat (3) @(negedge clk);
    arst = 1'b1;
    repeat (2) @(negedge clk);
    run_op(32'h4040_0000, 32'h3F80_0000, 0);

    for (int i = 0; i < 24; i++) begin
      ra = rand_fp();
      rb = rand_fp();
      run_op(ra, rb, bit'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

`ifdef FPU_DIV_TIMEOUT_EN
    begin
      bit got, saw;
      got = 0; saw = 0; w = 0;
      @(negedge clk); t_a = 32'h3FC0_0000; t_b = 32'h3F80_0000; t_start = 1'b1;
      while (!got && w < 200) begin
        @(negedge clk);
        if (t_div_start) saw = 1;
        if (t_done) got = 1; else w++;
      end
      chk("to_done_seen", 64'(got), 64'd1);
      chk("to_div_start_seen", 64'(saw), 64'd1);
      chk("to_response",
          64'({t_result, t_dbz, t_inv, t_ovf, t_unf, t_to, t_div_start}),
          64'({QNAN, 5'b00001, 1'b0}));
      t_start = 1'b0;
      repeat (2) @(negedge clk);
      chk("to_done_release", 64'(t_done), 64'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1, "time limit");
  end

endmodule
